// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared helpers for the round-robin N:1 registered multiplexer.
//   calc_chan_w : width of a channel index (at least 1 bit).
//   next_chan   : channel increment with wrap from n-1 back to 0.
package rr_mux_pkg;

    function automatic int calc_chan_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int next_chan(input int c, input int n);
        return (c >= n - 1) ? 0 : c + 1;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter.sv
// rr_arbiter: combinational round-robin grant selection.
// Ports:
//   req_i       - per-channel request vector
//   ptr_i       - highest-priority channel for this cycle
//   lock_i      - packet lock; only channel ptr_i may be granted
//   gnt_o       - granted channel index (equals ptr_i when nothing granted)
//   gnt_valid_o - a channel is granted
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CHAN_W   = calc_chan_w(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [CHAN_W-1:0]   ptr_i,
    input  logic                lock_i,
    output logic [CHAN_W-1:0]   gnt_o,
    output logic                gnt_valid_o
);

    logic [CHAN_W-1:0] scan_idx;

    always_comb begin
        gnt_o       = ptr_i;
        gnt_valid_o = 1'b0;
        scan_idx    = '0;
        if (lock_i) begin
            // Locked: hold the grant on the packet owner even while it idles.
            gnt_valid_o = req_i[ptr_i];
        end else begin
            // Scan ptr, ptr+1, ... modulo CHANNELS; first requester wins.
            for (int k = 0; k < CHANNELS; k++) begin
                scan_idx = CHAN_W'((int'(ptr_i) + k) % CHANNELS);
                if (!gnt_valid_o && req_i[scan_idx]) begin
                    gnt_valid_o = 1'b1;
                    gnt_o       = scan_idx;
                end
            end
        end
    end

endmodule

// File: rtl/rr_mux_n_1.sv
// rr_mux_n_1: N-input, W-bit registered multiplexer with round-robin
// arbitration and valid/ready handshakes. Each accepted beat is captured in a
// single output register tagged with its source channel.
// Optional feature macro: RR_MUX_LOCK_EN (adds in_last/out_last and packet lock).
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_data               - channel i at [i*WIDTH +: WIDTH]
//   in_valid / in_ready   - per-channel handshake; in_ready is one-hot or zero
//   in_last               - end-of-packet flag (RR_MUX_LOCK_EN only)
//   out_data / out_chan   - registered beat and its source channel
//   out_last              - registered last flag (RR_MUX_LOCK_EN only)
//   out_valid / out_ready - output handshake
module rr_mux_n_1
    import rr_mux_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int CHAN_W   = calc_chan_w(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
`ifdef RR_MUX_LOCK_EN
    input  logic [CHANNELS-1:0]       in_last,
`endif
    output logic [WIDTH-1:0]          out_data,
    output logic [CHAN_W-1:0]         out_chan,
`ifdef RR_MUX_LOCK_EN
    output logic                      out_last,
`endif
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]  data_q, data_d;
    logic [CHAN_W-1:0] chan_q, chan_d;
    logic              valid_q, valid_d;
    logic [CHAN_W-1:0] ptr_q, ptr_d;
    logic              lock_sel;
`ifdef RR_MUX_LOCK_EN
    logic              last_q, last_d;
    logic              lock_q, lock_d;
`endif

    logic              load;
    logic [CHAN_W-1:0] gnt;
    logic              gnt_valid;
    logic [CHAN_W-1:0] gnt_inc;
    logic [WIDTH-1:0]  sel_data;

`ifdef RR_MUX_LOCK_EN
    assign lock_sel = lock_q;
`else
    assign lock_sel = 1'b0;
`endif

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .CHAN_W   (CHAN_W)
    ) u_arb (
        .req_i       (in_valid),
        .ptr_i       (ptr_q),
        .lock_i      (lock_sel),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid)
    );

    // The register can take a new beat whenever it is empty or being drained.
    assign load     = !valid_q || out_ready;
    assign gnt_inc  = CHAN_W'(next_chan(int'(gnt), CHANNELS));
    assign sel_data = in_data[int'(gnt)*WIDTH +: WIDTH];

    always_comb begin
        in_ready = '0;
        if (load && gnt_valid) begin
            in_ready[gnt] = 1'b1;
        end
    end

    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
`ifdef RR_MUX_LOCK_EN
        last_d  = last_q;
        lock_d  = lock_q;
`endif
        if (load) begin
            if (gnt_valid) begin
                data_d  = sel_data;
                chan_d  = gnt;
                valid_d = 1'b1;
                ptr_d   = gnt_inc;
`ifdef RR_MUX_LOCK_EN
                last_d  = in_last[gnt];
                if (in_last[gnt]) begin
                    lock_d = 1'b0;
                end else begin
                    // Mid-packet: pin the pointer on the owner.
                    lock_d = 1'b1;
                    ptr_d  = gnt;
                end
`endif
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
`ifdef RR_MUX_LOCK_EN
            last_q  <= 1'b0;
            lock_q  <= 1'b0;
`endif
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
`ifdef RR_MUX_LOCK_EN
            last_q  <= last_d;
            lock_q  <= lock_d;
`endif
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;
`ifdef RR_MUX_LOCK_EN
    assign out_last  = last_q;
`endif

    // Producer obligation: data stays put while a request waits.
    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(in_ready));

    for (genvar i = 0; i < CHANNELS; i++) begin : g_stable
        a_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
            (in_valid[i] && !in_ready[i]) |=>
                (!in_valid[i] || $stable(in_data[i*WIDTH +: WIDTH])));
    end

endmodule

// File: doc/rr_mux_n_1.md
# rr_mux_n_1

Parametrised N-input, W-bit registered multiplexer with round-robin arbitration and valid/ready handshakes; successor to the fixed 2:1 4-bit combinational mux in the datapath library. It merges several producer streams onto one consumer stream, selecting among requesting channels fairly. Each accepted beat is captured into a single output register tagged with its source channel.

## Interface
- `WIDTH`, default 4: data bits per channel, ≥1.
- `CHANNELS`, default 4: number of input channels, ≥2; non-power-of-2 allowed.
- `CHAN_W`, default max(1, clog2(CHANNELS)): derived channel-index width; not overridden.

Ports, clock and reset first:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  CHANNELS  per-channel request.
- `in_ready`  out  CHANNELS  per-channel accept; at most one bit high.
- `in_last`  in  CHANNELS  end-of-packet flag; present only with RR_MUX_LOCK_EN.
- `out_data`  out  WIDTH  registered selected data.
- `out_chan`  out  CHAN_W  registered source-channel index.
- `out_last`  out  1  registered last flag; present only with RR_MUX_LOCK_EN.
- `out_valid`  out  1  output register holds a beat.
- `out_ready`  in  1  consumer accept.

## Operation
- Output register loads when `load = !out_valid || out_ready`.
- Grant: the first channel with `in_valid` high, scanning from `ptr` upward modulo CHANNELS. `in_ready[g] = load && in_valid[g]` for the granted g only; all other bits are 0.
- Transfer on channel i when `in_valid[i] && in_ready[i]`. On the same edge: out_data ← channel data, out_chan ← g, out_valid ← 1, ptr ← (g+1) mod CHANNELS. ptr wraps from CHANNELS-1 to 0.
- If `load` is high and no channel requests: out_valid ← 0, and out_data, out_chan and ptr hold.
- If `out_valid && !out_ready`: the register holds, all in_ready are 0, and ptr holds.
- Simultaneous output drain and new accept in one cycle is allowed (full throughput, 1 beat/cycle).
- `in_ready` depends combinationally on `in_valid`. Producers must not make `in_valid` depend on `in_ready`.
- A producer holds data stable while `in_valid && !in_ready`. This is checked by assertion only.

## Timing
- Latency: accepted beat visible on out_* at the next rising edge.
- Reset (asynchronous assert, synchronous deassert by system): out_valid=0, out_data=0, out_chan=0, out_last=0, ptr=0, lock=0.
- Reset mid-transfer: the pending beat is discarded; no handshake completes on the reset edge.
- Fairness: with all channels continuously valid and out_ready=1, the grant order is 0,1,…,CHANNELS-1,0,… Each requester is served within CHANNELS accepted beats.

## Configuration
- `RR_MUX_LOCK_EN` defined: adds the `in_last` and `out_last` ports and packet lock.
  - An accepted beat with in_last=0 sets lock=1 and ptr ← g, so the grant stays on g.
  - While locked, only channel g may be granted, even if it is idle. Other channels wait.
  - A beat accepted with in_last=1 clears lock and sets ptr ← g+1.
  - out_last mirrors the accepted in_last.
- Undefined: no last ports, no lock, and re-arbitration happens on every beat.

## Structure
- Package `rr_mux_pkg`: the CHAN_W derivation function, and a `next_chan` increment-with-wrap function.
- Sub-module `rr_arbiter`: combinational. Inputs: request vector, ptr, lock. Outputs: grant index and grant-valid.
- Top: output register, pointer/lock state, in_ready decode, and data select indexed by grant.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1. Out_valid drops to 0 immediately (asynchronously); ptr=0 after release, so first grant with all valid is channel 0.
- Round-robin: CHANNELS=4, all valid, out_ready=1. out_chan sequence is 0,1,2,3,0,1 on consecutive cycles; out_valid continuously 1.
- Backpressure: out_ready=0 for 3 cycles with a beat held (data 0xA, chan 2). out_data stays 0xA, all in_ready=0, ptr unchanged. After release, next grant is channel 3.
- Sparse/wrap: CHANNELS=3, only channel 0 valid, ptr=2. Grant is 0 and ptr becomes 1. Then no requests with out_ready=1: out_valid goes 0 while out_data holds.
- Lock (RR_MUX_LOCK_EN): channel 1 sends a 3-beat packet (last on beat 3) while channel 2 is continuously valid. Channel 2 is granted only after channel 1's last beat, even across a channel-1 idle cycle.
- Width: WIDTH=8, CHANNELS=5. Data pattern 0x10+i on channel i round-trips exactly; out_chan reaches 4 then wraps to 0.
